// File: rtl/alu_op_sequencer.sv
// Clocked ALU operand sequencer: read operand, dispatch to one functional unit, write back result.
// Optional EXEC watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module alu_op_sequencer #(
   parameter int unsigned          DATA_W    = 8,
   parameter int unsigned          N_UNITS   = 8,
   parameter int unsigned          OP_W      = 3,
   parameter logic [N_UNITS-1:0]   UNIT_MASK = 8'b1011_1111,
   parameter int unsigned          TIMEOUT   = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [OP_W-1:0]             opcode,
   input  logic [DATA_W-1:0]           data_in,
   output logic                        rd,
   output logic                        wr,
   output logic [DATA_W-1:0]           data_out,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [N_UNITS-1:0]          unit_start,
   output logic [DATA_W-1:0]           unit_data,
   input  logic [N_UNITS-1:0]          unit_done,
   input  logic [N_UNITS*DATA_W-1:0]   unit_result
);

   localparam int unsigned NSLOT = 2 ** OP_W;

   if (TIMEOUT == 0 || NSLOT < N_UNITS) begin : g_bad_params
      $error("alu_op_sequencer: illegal TIMEOUT/OP_W/N_UNITS combination");
   end

   typedef enum logic [2:0] {
      StIdle, StRead, StCapture, StDispatch, StExec, StWrite, StFinish, StFault
   } state_e;

   state_e state_q, state_d;

   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] operand_q;
   logic [DATA_W-1:0] result_q;
   logic              rd_q, wr_q, busy_q, done_q, error_q;
   logic [N_UNITS-1:0] unit_start_q;

   logic [NSLOT-1:0]   mask_ext;
   logic [NSLOT-1:0]   done_ext;
   logic               op_ok;
   logic               unit_hit;
   logic [DATA_W-1:0]  result_sel;
   logic [N_UNITS-1:0] op_onehot;

   // Pad to the full opcode range so out-of-range opcodes index a zero bit.
   assign mask_ext = NSLOT'(UNIT_MASK);
   assign done_ext = NSLOT'(unit_done);
   assign op_ok    = (32'(opcode) < N_UNITS) && mask_ext[opcode];
   assign unit_hit = done_ext[op_q];

   always_comb begin
      result_sel = '0;
      op_onehot  = '0;
      for (int k = 0; k < int'(N_UNITS); k++) begin
         if (op_q == OP_W'(k)) begin
            result_sel   = unit_result[k*DATA_W +: DATA_W];
            op_onehot[k] = 1'b1;
         end
      end
   end

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             timed_out;

   // Counts EXEC cycles already spent; zero on the first EXEC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == StExec) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= '0;
      end
   end

   assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = op_ok ? StRead : StFault;
            end
         end
         StRead:     state_d = StCapture;
         StCapture:  state_d = StDispatch;
         StDispatch: state_d = StExec;
         StExec: begin
            // A unit_done arriving on the last allowed cycle still completes normally.
            if (unit_hit) begin
               state_d = StWrite;
`ifdef ALU_SEQ_TIMEOUT_EN
            end else if (timed_out) begin
               state_d = StFault;
`endif
            end
         end
         StWrite:  state_d = StFinish;
         StFinish: state_d = StIdle;
         StFault:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath registers and outputs are flops keyed off the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= '0;
         operand_q    <= '0;
         result_q     <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         unit_start_q <= '0;
      end else begin
         if (state_q == StIdle && start) begin
            op_q <= opcode;
         end
         if (state_q == StCapture) begin
            operand_q <= data_in;
         end
         if (state_q == StExec && unit_hit) begin
            result_q <= result_sel;
         end
         rd_q         <= (state_d == StRead);
         wr_q         <= (state_d == StWrite);
         busy_q       <= (state_d != StIdle);
         done_q       <= (state_d == StFinish) || (state_d == StFault);
         error_q      <= (state_d == StFault);
         unit_start_q <= (state_d == StDispatch) ? op_onehot : '0;
      end
   end

   assign rd         = rd_q;
   assign wr         = wr_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign unit_start = unit_start_q;
   assign unit_data  = operand_q;
   assign data_out   = result_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (TIMEOUT = 4).
`timescale 1ns/1ps
module tb_alu_op_sequencer;

   localparam int DW = 8;
   localparam int NU = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    opcode = '0;
   logic [DW-1:0] data_in = '0;
   logic          rd, wr, busy, done, error;
   logic [DW-1:0] data_out, unit_data;
   logic [NU-1:0] unit_start;
   logic [NU-1:0] unit_done = '0;
   logic [NU*DW-1:0] unit_result = '0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .DATA_W(DW), .N_UNITS(NU), .OP_W(3), .UNIT_MASK(8'b1011_1111), .TIMEOUT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .data_in(data_in),
      .rd(rd), .wr(wr), .data_out(data_out), .busy(busy), .done(done), .error(error),
      .unit_start(unit_start), .unit_data(unit_data), .unit_done(unit_done),
      .unit_result(unit_result)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue start for one edge (edge 0); returns in cycle 1.
   task automatic issue(input logic [2:0] op);
      start  = 1'b1;
      opcode = op;
      tick();
      start  = 1'b0;
   endtask

   task automatic set_result(input int slot, input logic [DW-1:0] val);
      unit_result = '0;
      unit_result[slot*DW +: DW] = val;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_strobes"}, {rd, wr, done, error}, 4'b0);
      check({tag, "_ustart"}, unit_start, 0);
   endtask

   initial begin
      // Reset state
      #2;
      check_idle("rst");
      check("rst_dout", data_out, 0);
      check("rst_udata", unit_data, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check_idle("post_rst");

      // unit_done outside EXEC is ignored
      unit_done = 8'hFF;
      tick();
      unit_done = '0;
      tick();
      check_idle("stray_done");

      // Normal op: opcode 0, operand 3C, result 78 two cycles after unit_start
      issue(3'd0);
      check("n_rd_c1", rd, 1);
      check("n_busy_c1", busy, 1);
      tick();
      check("n_rd_c2", rd, 0);
      data_in = 8'h3C;
      tick();
      data_in = 8'h00;
      check("n_ustart_c3", unit_start, 8'b0000_0001);
      check("n_udata_c3", unit_data, 8'h3C);
      tick();
      check("n_ustart_c4", unit_start, 0);
      check("n_udata_c4", unit_data, 8'h3C);
      tick();
      unit_done = 8'b0000_0001;
      set_result(0, 8'h78);
      check("n_wr_c5", wr, 0);
      tick();
      unit_done = '0;
      check("n_wr_c6", wr, 1);
      check("n_dout_c6", data_out, 8'h78);
      check("n_done_c6", done, 0);
      tick();
      check("n_done_c7", {wr, done, error}, 3'b010);
      tick();
      check_idle("n_end");

      // Unpopulated opcode 6
      issue(3'd6);
      check("inv_c1", {done, error, rd, wr}, 4'b1100);
      check("inv_ustart", unit_start, 0);
      tick();
      check_idle("inv_end");

      // Crosstalk on slot 2 during EXEC of opcode 5, and start ignored while busy
      issue(3'd5);
      tick();
      data_in = 8'h5A;
      tick();
      check("x_ustart_c3", unit_start, 8'b0010_0000);
      tick();
      unit_done = 8'b0000_0100;
      set_result(2, 8'hFF);
      start  = 1'b1;
      opcode = 3'd2;
      tick();
      unit_done = '0;
      start = 1'b0;
      check("x_wr_c5", wr, 0);
      check("x_busy_c5", busy, 1);
      tick();
      unit_done = 8'b0010_0000;
      set_result(5, 8'hA5);
      tick();
      unit_done = '0;
      check("x_wr_c7", wr, 1);
      check("x_dout_c7", data_out, 8'hA5);
      tick();
      check("x_done_c8", {done, error}, 2'b10);
      tick();
      check_idle("x_end");

      // Unit never responds
      issue(3'd1);
      tick();
      tick();
      tick();
`ifdef ALU_SEQ_TIMEOUT_EN
      // EXEC cycles 4..7, fault in cycle 8
      tick();
      tick();
      tick();
      check("to_c7", {done, error, busy}, 3'b001);
      tick();
      check("to_c8", {done, error, wr}, 3'b110);
      tick();
      check_idle("to_end");
`else
      for (int i = 0; i < 20; i++) tick();
      check("hang_busy", busy, 1);
      check("hang_strobes", {done, error, wr}, 3'b000);
      #3;
      rst_n = 1'b0;
      #1;
      check_idle("hang_rst");
      tick();
      rst_n = 1'b1;
      tick();
`endif

      // Reset while unit_start is high, then a fresh minimum-latency op
      issue(3'd3);
      tick();
      data_in = 8'h11;
      tick();
      check("r_ustart_c3", unit_start, 8'b0000_1000);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("r_async");
      check("r_udata", unit_data, 0);
      tick();
      check_idle("r_held");
      rst_n = 1'b1;
      tick();
      issue(3'd3);
      tick();
      data_in = 8'h11;
      tick();
      check("m_udata_c3", unit_data, 8'h11);
      tick();
      unit_done = 8'b0000_1000;
      set_result(3, 8'h22);
      tick();
      unit_done = '0;
      check("m_wr_c5", {wr, data_out}, {1'b1, 8'h22});
      tick();
      check("m_done_c6", {done, error}, 2'b10);
      tick();
      check_idle("m_end");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
